// File: rtl/wb_arbiter_pkg.sv
// Shared bus definitions for the SRAM arbiter and its watchdog.
package wb_arbiter_pkg;

    // Default bus geometry shared with spi_slave and wb_sram
    localparam int unsigned BUS_WIDTH = 8;
    localparam int unsigned BUS_ABITS = 7;

    // Width of the saturating watchdog-abort counter
    localparam int unsigned TMO_CNT_W = 8;

    // Arbiter state encodings
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS0 = 2'd1,
        ST_BUS1 = 2'd2
    } arb_state_e;

    // One-hot grant vector for a given arbiter state
    function automatic logic [1:0] gnt_of(input arb_state_e s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            ST_BUS0: g = 2'b01;
            ST_BUS1: g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

    // Increment that sticks at all-ones
    function automatic logic [TMO_CNT_W-1:0] sat_inc(input logic [TMO_CNT_W-1:0] v);
        logic [TMO_CNT_W-1:0] r;
        r = v;
        if (v != '1) begin
            r = v + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_arbiter_watchdog.sv
// No-ack watchdog: aborts a strobe that has waited TIMEOUT cycles for ack
// and keeps a saturating count of those aborts.
module wb_watchdog
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TBITS   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 stb_i,      // granted strobe, before abort masking
    input  logic                 ack_i,
    input  logic                 clr_i,      // grant is changing this cycle
    output logic                 abort_o,
    output logic [TMO_CNT_W-1:0] tmo_cnt_o
);

    localparam logic [TBITS-1:0] LIMIT = TBITS'(TIMEOUT - 1);

    logic [TBITS-1:0]     cnt_q, cnt_d;
    logic [TMO_CNT_W-1:0] tmo_q, tmo_d;

    // Counter value k-1 during the k-th wait cycle, so the abort lands on wait cycle TIMEOUT;
    // an ack in that same cycle suppresses the abort.
    assign abort_o   = stb_i & ~ack_i & (cnt_q == LIMIT);
    assign tmo_cnt_o = tmo_q;

    // Next wait count and abort tally
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        tmo_d = tmo_q;
        if (clr_i || !stb_i || ack_i || abort_o) begin
            cnt_d = '0;
        end
        if (abort_o) begin
            tmo_d = sat_inc(tmo_q);
        end
    end

    // Watchdog state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            tmo_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Two-requester round-robin arbiter in front of the shared SRAM port.
// Grants whole cyc-framed cycles; a watchdog aborts strobes the SRAM never acks.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH   = BUS_WIDTH,
    parameter int unsigned ABITS   = BUS_ABITS,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned TBITS   = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    // requester 0: host-access bus
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic             m0_bst_i,
    input  logic [ABITS-1:0] m0_adr_i,
    input  logic [WIDTH-1:0] m0_dat_i,
    output logic [WIDTH-1:0] m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    // requester 1: acquisition writer
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic             m1_bst_i,
    input  logic [ABITS-1:0] m1_adr_i,
    input  logic [WIDTH-1:0] m1_dat_i,
    output logic [WIDTH-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    // SRAM side
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic             s_bst_o,
    output logic [ABITS-1:0] s_adr_o,
    output logic [WIDTH-1:0] s_dat_o,
    input  logic [WIDTH-1:0] s_dat_i,
    input  logic             s_ack_i,
    // status
    output logic [1:0]       gnt_o,
    output logic [7:0]       tmo_cnt_o
);

    arb_state_e       state_q, state_d;
    logic             last_q, last_d;      // 1: requester 1 was granted most recently
    logic [WIDTH-1:0] m0_dat_q, m1_dat_q;
    logic             stb_req;
    logic             abort;
    logic             grant_chg;

    // Arbitration: registered grant, round-robin on ties, handover without idle gap
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? ST_BUS0 : ST_BUS1;
                end else if (m0_cyc_i) begin
                    state_d = ST_BUS0;
                end else if (m1_cyc_i) begin
                    state_d = ST_BUS1;
                end
            end
            ST_BUS0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? ST_BUS1 : ST_IDLE;
                end
            end
            ST_BUS1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? ST_BUS0 : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_BUS0) begin
            last_d = 1'b0;
        end else if (state_d == ST_BUS1) begin
            last_d = 1'b1;
        end
    end

    // Strobe request of the granted requester, before the watchdog masks it
    always_comb begin
        stb_req = 1'b0;
        unique case (state_q)
            ST_BUS0: stb_req = m0_cyc_i & m0_stb_i;
            ST_BUS1: stb_req = m1_cyc_i & m1_stb_i;
            default: stb_req = 1'b0;
        endcase
    end

    // Bus mux: granted requester drives the SRAM, SRAM ack/data route back to it
    always_comb begin
        s_cyc_o  = 1'b0;
        s_we_o   = 1'b0;
        s_bst_o  = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = m0_dat_q;
        m1_dat_o = m1_dat_q;
        unique case (state_q)
            ST_BUS0: begin
                s_cyc_o  = m0_cyc_i;
                s_we_o   = m0_we_i;
                s_bst_o  = m0_bst_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
            ST_BUS1: begin
                s_cyc_o  = m1_cyc_i;
                s_we_o   = m1_we_i;
                s_bst_o  = m1_bst_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end
            default: ;
        endcase
    end

    assign grant_chg = (state_d != state_q);
    assign s_stb_o   = stb_req & ~abort;
    assign m0_err_o  = abort & (state_q == ST_BUS0);
    assign m1_err_o  = abort & (state_q == ST_BUS1);
    assign gnt_o     = gnt_of(state_q);

    // Arbiter state and per-requester read-data hold registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            last_q   <= 1'b1;
            m0_dat_q <= '0;
            m1_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            m0_dat_q <= m0_dat_o;
            m1_dat_q <= m1_dat_o;
        end
    end

    wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .TBITS   (TBITS)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .stb_i     (stb_req),
        .ack_i     (s_ack_i),
        .clr_i     (grant_chg),
        .abort_o   (abort),
        .tmo_cnt_o (tmo_cnt_o)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a one-wait-state SRAM model.
module tb_wb_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_cyc, m0_stb, m0_we, m0_bst, m1_cyc, m1_stb, m1_we, m1_bst;
    logic [6:0] m0_adr, m1_adr, s_adr;
    logic [7:0] m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic       m0_ack, m0_err, m1_ack, m1_err;
    logic       s_cyc, s_stb, s_we, s_bst, s_ack;
    logic [1:0] gnt;
    logic [7:0] tmo_cnt;

    logic [7:0] mem [0:127];
    logic       ack_q;
    logic       ack_en;
    logic [7:0] wbuf [4];
    logic [7:0] rbuf [4];
    int         passed = 0;
    int         total  = 0;
    int         ack0_n = 0;
    int         ack1_n = 0;
    int         held_bad;
    int         m0_got;
    int         bad;
    int         a0, a1;

    always #5 clk = ~clk;

    wb_arbiter #(.WIDTH(8), .ABITS(7), .TIMEOUT(15), .TBITS(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_bst_i(m0_bst),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_bst_i(m1_bst),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_bst_o(s_bst),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack),
        .gnt_o(gnt), .tmo_cnt_o(tmo_cnt)
    );

    // SRAM model: one wait state per access, write on the acked edge
    assign s_ack   = ack_q;
    assign s_dat_i = mem[s_adr];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
        end else begin
            if (ack_q && s_cyc && s_stb && s_we) mem[s_adr] <= s_dat_o;
            ack_q <= ack_en && s_cyc && s_stb && !ack_q;
        end
    end

    always @(posedge clk) begin
        if (m0_ack) ack0_n <= ack0_n + 1;
        if (m1_ack) ack1_n <= ack1_n + 1;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no end of test, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_m(input int m, input logic cyc, input logic stb, input logic we,
                         input logic bst, input logic [6:0] adr, input logic [7:0] dat);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_bst = bst; m0_adr = adr; m0_dat = dat;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_bst = bst; m1_adr = adr; m1_dat = dat;
        end
    endtask

    // Drive an n-word transfer; write data from wbuf, read data into rbuf
    task automatic burst(input int m, input logic we, input logic [6:0] adr, input int n);
        logic [6:0] a;
        logic       got;
        a = adr;
        for (int k = 0; k < n; k++) begin
            set_m(m, 1'b1, 1'b1, we, (n > 1), a, wbuf[k]);
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                @(negedge clk);
                if ((m == 0) ? m0_ack : m1_ack) begin
                    got = 1'b1;
                    rbuf[k] = (m == 0) ? m0_dat_o : m1_dat_o;
                end
            end
            check("burst_ack", got, 1);
            @(posedge clk); #1;
            a = a + 7'd1;
        end
        set_m(m, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00, 8'h00);
    endtask

    initial begin
        rst_n  = 1'b0;
        ack_en = 1'b1;
        set_m(0, 0, 0, 0, 0, 7'h00, 8'h00);
        set_m(1, 0, 0, 0, 0, 7'h00, 8'h00);
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3; wbuf[2] = 8'h7E; wbuf[3] = 8'h19;

        // Reset values
        @(negedge clk);
        check("rst_s_cyc", s_cyc, 0);
        check("rst_s_stb", s_stb, 0);
        check("rst_gnt", gnt, 2'b00);
        check("rst_tmo", tmo_cnt, 8'h00);
        check("rst_acks_errs", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
        check("rst_dat_o", {m0_dat_o, m1_dat_o}, 16'h0000);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Tie straight after reset: m0 first, then m1 back-to-back
        @(posedge clk); #1;
        set_m(0, 1, 1, 1, 0, 7'h01, 8'hA0);
        set_m(1, 1, 1, 1, 0, 7'h02, 8'hB1);
        @(negedge clk);
        check("arb_latency_scyc", s_cyc, 0);
        check("arb_latency_gnt", gnt, 2'b00);
        @(negedge clk);
        check("tie0_gnt", gnt, 2'b01);
        check("tie0_adr", s_adr, 7'h01);
        check("tie0_m1_ack", m1_ack, 0);
        @(negedge clk);
        check("tie0_m0_ack", m0_ack, 1);
        @(posedge clk); #1;
        set_m(0, 0, 0, 0, 0, 7'h00, 8'h00);
        @(negedge clk);
        check("drop_scyc_comb", s_cyc, 0);
        @(negedge clk);
        check("handover_gnt", gnt, 2'b10);
        check("handover_scyc", s_cyc, 1);
        check("handover_adr", s_adr, 7'h02);
        @(negedge clk);
        check("handover_m1_ack", m1_ack, 1);
        @(posedge clk); #1;
        set_m(1, 0, 0, 0, 0, 7'h00, 8'h00);
        @(posedge clk); #1;
        set_m(0, 1, 1, 0, 0, 7'h01, 8'h00);
        set_m(1, 1, 1, 0, 0, 7'h02, 8'h00);
        @(negedge clk);
        check("rr_idle_gnt", gnt, 2'b00);
        @(negedge clk);
        check("rr_gnt", gnt, 2'b01);
        @(posedge clk); #1;
        set_m(0, 0, 0, 0, 0, 7'h00, 8'h00);
        set_m(1, 0, 0, 0, 0, 7'h00, 8'h00);
        @(posedge clk); #1;
        check("tie_mem1", mem[1], 8'hA0);
        check("tie_mem2", mem[2], 8'hB1);

        // Single write from m0
        a0 = ack0_n;
        a1 = ack1_n;
        set_m(0, 1, 1, 1, 0, 7'h0F, 8'h01);
        @(negedge clk);
        check("single_lat", s_cyc, 0);
        @(negedge clk);
        check("single_scyc", s_cyc, 1);
        check("single_gnt", gnt, 2'b01);
        @(negedge clk);
        check("single_acks", {m0_ack, m1_ack}, 2'b10);
        @(posedge clk); #1;
        set_m(0, 0, 0, 0, 0, 7'h00, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check("single_gnt_idle", gnt, 2'b00);
        check("single_mem", mem[7'h0F], 8'h01);
        check("single_ack0_cnt", ack0_n - a0, 1);
        check("single_ack1_cnt", ack1_n - a1, 0);

        // m1 burst write, m0 requests mid-burst and must wait
        @(posedge clk); #1;
        held_bad = 0;
        m0_got   = 0;
        fork
            burst(1, 1'b1, 7'h20, 4);
            begin
                repeat (3) @(posedge clk);
                #1;
                set_m(0, 1, 1, 0, 1, 7'h20, 8'h00);
                for (int k = 0; k < 60 && m0_got == 0; k++) begin
                    @(negedge clk);
                    if (m1_cyc && gnt != 2'b10) held_bad++;
                    if (gnt == 2'b01) begin
                        m0_got = 1;
                        if (m1_cyc) held_bad++;
                    end
                end
            end
        join
        check("preempt_none", held_bad, 0);
        check("m0_granted_after", m0_got, 1);
        burst(0, 1'b0, 7'h20, 3);
        check("bw_mem20", mem[7'h20], 8'h5A);
        check("bw_mem21", mem[7'h21], 8'hC3);
        check("bw_mem22", mem[7'h22], 8'h7E);
        check("bw_mem23", mem[7'h23], 8'h19);
        check("br_rd0", rbuf[0], 8'h5A);
        check("br_rd1", rbuf[1], 8'hC3);
        check("br_rd2", rbuf[2], 8'h7E);

        // Watchdog: SRAM never acks, m0 holds stb
        @(posedge clk); #1;
        ack_en = 1'b0;
        set_m(0, 1, 1, 1, 0, 7'h40, 8'hEE);
        @(negedge clk);
        bad = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (m0_err || !s_stb) bad++;
        end
        check("wd_no_early_err", bad, 0);
        check("wd_tmo_before", tmo_cnt, 8'h00);
        @(negedge clk);
        check("wd_err", m0_err, 1);
        check("wd_stb_forced", s_stb, 0);
        check("wd_m1_err", m1_err, 0);
        check("wd_scyc_held", s_cyc, 1);
        @(posedge clk); #1;
        ack_en = 1'b1;
        set_m(0, 0, 0, 0, 0, 7'h00, 8'h00);
        set_m(1, 1, 1, 1, 0, 7'h41, 8'h55);
        @(negedge clk);
        check("wd_tmo_cnt", tmo_cnt, 8'h01);
        check("wd_err_pulse", m0_err, 0);
        @(negedge clk);
        check("wd_then_m1_gnt", gnt, 2'b10);
        @(negedge clk);
        check("wd_m1_ack", m1_ack, 1);
        @(posedge clk); #1;
        set_m(1, 0, 0, 0, 0, 7'h00, 8'h00);
        @(negedge clk);
        check("wd_m1_mem", mem[7'h41], 8'h55);

        // Asynchronous reset in the middle of an m1 burst
        @(posedge clk); #1;
        set_m(1, 1, 1, 0, 1, 7'h20, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("mid_gnt", gnt, 2'b10);
        check("mid_dat", m1_dat_o, 8'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_scyc", s_cyc, 0);
        check("arst_gnt", gnt, 2'b00);
        check("arst_tmo", tmo_cnt, 8'h00);
        check("arst_m1_ack", m1_ack, 0);
        check("arst_dat", {m0_dat_o, m1_dat_o}, 16'h0000);
        set_m(1, 0, 0, 0, 0, 7'h00, 8'h00);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        set_m(0, 1, 1, 0, 0, 7'h03, 8'h00);
        set_m(1, 1, 1, 0, 0, 7'h04, 8'h00);
        @(negedge clk);
        @(negedge clk);
        check("post_rst_tie", gnt, 2'b01);
        @(posedge clk); #1;
        set_m(0, 0, 0, 0, 0, 7'h00, 8'h00);
        set_m(1, 0, 0, 0, 0, 7'h00, 8'h00);
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-requester arbiter in front of the shared Wishbone-like SRAM port (wb_sram).
- Requester 0 is the spi_slave host-access bus; requester 1 is the acquisition/correlator writer.
- Grants whole bus cycles (cyc-framed, classic or burst) with round-robin fairness.
- A no-ack watchdog keeps a dead transfer from locking the SRAM.

Parameters:
- WIDTH, 8: data bus width.
- ABITS, 7: address width.
- TIMEOUT, 15: cycles stb may wait for ack before the arbiter aborts the strobe; legal range 1..2^TBITS-1.
- TBITS, 4: watchdog counter width.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- m0_cyc_i, m0_stb_i, m0_we_i, m0_bst_i  in  1 each  requester 0 bus controls.
- m0_adr_i  in  ABITS  requester 0 address.
- m0_dat_i  in  WIDTH  requester 0 write data.
- m0_dat_o  out  WIDTH  requester 0 read data.
- m0_ack_o  out  1  requester 0 acknowledge.
- m0_err_o  out  1  requester 0 timeout abort.
- m1_*  same set as m0_*, for requester 1.
- s_cyc_o, s_stb_o, s_we_o, s_bst_o  out  1 each  to SRAM.
- s_adr_o  out  ABITS  to SRAM.
- s_dat_o  out  WIDTH  write data to SRAM.
- s_dat_i  in  WIDTH  read data from SRAM.
- s_ack_i  in  1  SRAM acknowledge.
- gnt_o  out  2  one-hot current grant, for status/debug.
- tmo_cnt_o  out  8  saturating count of watchdog aborts.

Behaviour:
- Clocking: all state is on posedge clk_i.
- Reset: rst_ni low clears immediately, with no clock needed.
  - State goes to IDLE, last-granted goes to 1 (requester 0 wins the first tie), watchdog to 0, tmo_cnt_o to 0.
  - All s_* outputs, m*_ack_o, m*_err_o and gnt_o go to 0; m*_dat_o go to 0.
  - Reset asserted mid-transfer drops s_cyc_o at once; requesters see no ack.
- States and transitions:
  - IDLE: s_cyc_o=0.
    - Only m0_cyc_i high: go BUS0. Only m1_cyc_i high: go BUS1.
    - Both high: go to the requester that is not last-granted.
    - Grant is registered, so arbitration latency is 1 cycle from cyc_i to s_cyc_o.
  - BUSn: s_cyc/stb/we/bst/adr/dat_o are driven combinationally from requester n. s_ack_i and s_dat_i route to mn_ack_o and mn_dat_o.
    - The non-granted requester sees ack=0, err=0 and dat_o held at its last value.
    - Last-granted is set to n on entry.
  - Leaving BUSn when mn_cyc_i falls: s_cyc_o falls in the same cycle (combinational).
    - If the other requester's cyc is high in that cycle, the next state is BUS(other): back-to-back with no idle gap.
    - Otherwise the next state is IDLE.
- Preemption: none. Grant is held for the full cyc, however long the burst.
- Watchdog:
  - Counter clears on s_ack_i, on s_stb_o low, or on a grant change. It increments while s_stb_o && !s_ack_i.
  - When it reaches TIMEOUT: mn_err_o pulses for exactly 1 cycle, s_stb_o is forced low in that cycle, the counter clears, and tmo_cnt_o increments, saturating at 255.
  - The state stays BUSn until the requester drops cyc.
- Simultaneous events:
  - s_ack_i arriving on the timeout cycle: the ack wins, with no err and no increment.
  - Both cyc rising in the same cycle from IDLE: round-robin rule applies.
  - One requester dropping cyc while the other raises it in the same cycle: handover as above.
- gnt_o: 2'b01 in BUS0, 2'b10 in BUS1, 2'b00 in IDLE.

Decomposition:
- Shared package (tart_bus_pkg or the codebase's include file) holds:
  - state encodings IDLE=0, BUS0=1, BUS1=2;
  - the default WIDTH/ABITS constants shared with spi_slave and wb_sram.
- One natural sub-module: wb_watchdog (timeout counter, err pulse, saturating abort counter), parameterised by TIMEOUT/TBITS.
- The mux and FSM stay in wb_arbiter.

Test Plan:
- Reset, then m0 single write adr 0x0F dat 0x01. Expect s_cyc_o 1 cycle after m0_cyc_i, SRAM[0x0F]=0x01, m0_ack_o once, gnt_o 01 then 00; m1 sees ack=0.
- Both cyc raised together right after reset. Expect m0 granted first (gnt_o=01); m1 granted in the cycle after m0 drops cyc (gnt_o=10) with no IDLE gap. Repeat both together: m0 wins again, since BUS1 was last, round-robin.
- m1 4-word burst write from adr 0x20 while m0 requests mid-burst. Expect all 4 words written to 0x20..0x23 and m0 held off until m1_cyc_i falls; then an m0 burst read of 3 returns the data m1 wrote.
- SRAM ack forced low with TIMEOUT=15 and m0 stb held. Expect m0_err_o high exactly on the 15th wait cycle, s_stb_o low that cycle, tmo_cnt_o=1; after m0 drops cyc, m1 is granted.
- rst_ni pulsed low mid m1 burst (asynchronously, between clock edges). Expect s_cyc_o and gnt_o 0 immediately, tmo_cnt_o 0, and first tie after release goes to m0.
